// File: rtl/puf_gen_one.sv
// Ring-oscillator PUF emulation: the 2-bit challenge picks an oscillator pair, rising edges of
// A and B are counted over WINDOW cycles, and the response is 1 when A is faster (a tie gives 0).
module puf_gen_one #(
    parameter int          WINDOW       = 256,
    parameter int          CNT_W        = 16,
    parameter logic [31:0] PERIOD_TABLE = 32'h70331542
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] control_input,
    output logic       output_signal,
    output logic       resp_valid
);
    localparam int WIN_W = $clog2(WINDOW + 1);
    localparam logic [WIN_W-1:0] WIN_END = WIN_W'(WINDOW);
    localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, MEASURE, COMPARE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [1:0]       chal_q, chal_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [3:0]       ph_a_q, ph_a_d, ph_b_q, ph_b_d;
    logic             osc_a_q, osc_a_d, osc_b_q, osc_b_d;
    logic             rise_a_q, rise_a_d, rise_b_q, rise_b_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic             out_q, out_d, vld_q, vld_d;
    logic [7:0]       entry;
    logic             clear;

    // Nibble values are half-period minus one, i.e. the phase at which the oscillator toggles.
    assign entry = PERIOD_TABLE[{chal_q, 3'b000} +: 8];

    always_comb begin
        state_d  = state_q;
        chal_d   = chal_q;
        win_d    = win_q;
        ph_a_d   = ph_a_q;
        ph_b_d   = ph_b_q;
        osc_a_d  = osc_a_q;
        osc_b_d  = osc_b_q;
        rise_a_d = 1'b0;
        rise_b_d = 1'b0;
        cnt_a_d  = (rise_a_q && cnt_a_q != '1) ? cnt_a_q + CNT_ONE : cnt_a_q;
        cnt_b_d  = (rise_b_q && cnt_b_q != '1) ? cnt_b_q + CNT_ONE : cnt_b_q;
        out_d    = out_q;
        vld_d    = vld_q;
        clear    = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            out_d   = 1'b0;
            vld_d   = 1'b0;
            clear   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    chal_d  = control_input;
                    clear   = 1'b1;
                    state_d = MEASURE;
                end
                MEASURE, HOLD: begin
                    if (control_input != chal_q) begin
                        chal_d  = control_input;
                        vld_d   = 1'b0;
                        clear   = 1'b1;
                        state_d = MEASURE;
                    end else if (state_q == MEASURE) begin
                        if (win_q == WIN_END) begin
                            // Extra cycle lets the edge pulse from the last window cycle land in the counter.
                            state_d = COMPARE;
                        end else begin
                            win_d = win_q + WIN_ONE;
                            if (ph_a_q == entry[3:0]) begin
                                ph_a_d   = 4'd0;
                                osc_a_d  = ~osc_a_q;
                                rise_a_d = ~osc_a_q;
                            end else begin
                                ph_a_d = ph_a_q + 4'd1;
                            end
                            if (ph_b_q == entry[7:4]) begin
                                ph_b_d   = 4'd0;
                                osc_b_d  = ~osc_b_q;
                                rise_b_d = ~osc_b_q;
                            end else begin
                                ph_b_d = ph_b_q + 4'd1;
                            end
                        end
                    end
                end
                COMPARE: begin
                    out_d   = (cnt_a_q > cnt_b_q);
                    vld_d   = 1'b1;
                    state_d = HOLD;
                end
                default: state_d = IDLE;
            endcase
        end

        if (clear) begin
            win_d    = '0;
            ph_a_d   = 4'd0;
            ph_b_d   = 4'd0;
            osc_a_d  = 1'b0;
            osc_b_d  = 1'b0;
            rise_a_d = 1'b0;
            rise_b_d = 1'b0;
            cnt_a_d  = '0;
            cnt_b_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            chal_q   <= 2'd0;
            win_q    <= '0;
            ph_a_q   <= 4'd0;
            ph_b_q   <= 4'd0;
            osc_a_q  <= 1'b0;
            osc_b_q  <= 1'b0;
            rise_a_q <= 1'b0;
            rise_b_q <= 1'b0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            out_q    <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            chal_q   <= chal_d;
            win_q    <= win_d;
            ph_a_q   <= ph_a_d;
            ph_b_q   <= ph_b_d;
            osc_a_q  <= osc_a_d;
            osc_b_q  <= osc_b_d;
            rise_a_q <= rise_a_d;
            rise_b_q <= rise_b_d;
            cnt_a_q  <= cnt_a_d;
            cnt_b_q  <= cnt_b_d;
            out_q    <= out_d;
            vld_q    <= vld_d;
        end
    end

    assign output_signal = out_q;
    assign resp_valid    = vld_q;
endmodule

// File: tb/tb_puf_gen_one.sv
// Bench for puf_gen_one: default-table and all-zero-table instances driven together,
// checked each cycle against a response/latency model plus directed literal checks.
module tb_puf_gen_one;
    localparam int          W   = 256;
    localparam logic [31:0] DEF = 32'h70331542;
    localparam logic [31:0] ZT  = 32'h00000000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] control_input = 2'd0;
    logic       out_d, vld_d, out_z, vld_z;

    int n_chk  = 0;
    int n_pass = 0;

    puf_gen_one #(.WINDOW(W), .CNT_W(16), .PERIOD_TABLE(DEF)) dut (
        .clk(clk), .rst(rst), .enable(enable), .control_input(control_input),
        .output_signal(out_d), .resp_valid(vld_d)
    );

    puf_gen_one #(.WINDOW(W), .CNT_W(16), .PERIOD_TABLE(ZT)) dut_z (
        .clk(clk), .rst(rst), .enable(enable), .control_input(control_input),
        .output_signal(out_z), .resp_valid(vld_z)
    );

    always #5 clk = ~clk;

    // Rising edges of an oscillator toggling every hp cycles, starting low: odd toggles within W.
    function automatic int edges(input int hp);
        int toggles;
        toggles = W / hp;
        return (toggles + 1) / 2;
    endfunction

    function automatic logic resp(input logic [31:0] tbl, input int c);
        int hpa, hpb;
        hpa = int'(tbl[8*c +: 4]) + 1;
        hpb = int'(tbl[8*c+4 +: 4]) + 1;
        return edges(hpa) > edges(hpb);
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    // Model: a response appears W+2 edges after a measurement starts; a challenge change restarts it.
    int         m_cyc  = 0;
    int         m_done = -1;
    logic       m_act  = 1'b0;
    logic [1:0] m_chal = 2'd0;
    logic       m_vld  = 1'b0;
    logic       m_out_d = 1'b0;
    logic       m_out_z = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act   <= 1'b0;
            m_vld   <= 1'b0;
            m_out_d <= 1'b0;
            m_out_z <= 1'b0;
            m_done  <= -1;
            m_cyc   <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (!enable) begin
                m_act   <= 1'b0;
                m_vld   <= 1'b0;
                m_out_d <= 1'b0;
                m_out_z <= 1'b0;
            end else if (!m_act) begin
                m_act  <= 1'b1;
                m_chal <= control_input;
                m_done <= m_cyc + W + 2;
            end else if (m_cyc == m_done) begin
                m_vld   <= 1'b1;
                m_out_d <= resp(DEF, int'(m_chal));
                m_out_z <= resp(ZT, int'(m_chal));
            end else if (control_input != m_chal) begin
                m_chal <= control_input;
                m_vld  <= 1'b0;
                m_done <= m_cyc + W + 2;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_vld",   int'(vld_d), int'(m_vld));
        chk("model_out",   int'(out_d), int'(m_out_d));
        chk("model_vld_z", int'(vld_z), int'(m_vld));
        chk("model_out_z", int'(out_z), int'(m_out_z));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Pin the model against hand-computed edge counts and responses.
        chk("edges_hp3", edges(3), 43);
        chk("edges_hp5", edges(5), 26);
        chk("edges_hp6", edges(6), 21);
        chk("edges_hp2", edges(2), 64);
        chk("edges_hp4", edges(4), 32);
        chk("edges_hp1", edges(1), 128);
        chk("edges_hp8", edges(8), 16);
        chk("resp_c0", int'(resp(DEF, 0)), 1);
        chk("resp_c1", int'(resp(DEF, 1)), 0);
        chk("resp_c2", int'(resp(DEF, 2)), 0);
        chk("resp_c3", int'(resp(DEF, 3)), 1);
        for (int c = 0; c < 4; c++) chk("resp_zero_table", int'(resp(ZT, c)), 0);

        tick(2);
        chk("reset_out", int'(out_d), 0);
        chk("reset_vld", int'(vld_d), 0);
        rst = 1'b0;
        enable = 1'b1;
        control_input = 2'd0;
        tick(50);
        rst = 1'b1;
        #1;
        chk("rst_mid_out", int'(out_d), 0);
        chk("rst_mid_vld", int'(vld_d), 0);
        tick(3);
        chk("rst_hold_vld", int'(vld_d), 0);
        rst = 1'b0;

        // Latency from the enabling edge.
        tick(1);
        tick(W + 1);
        chk("lat_early_vld", int'(vld_d), 0);
        tick(1);
        chk("lat_c0_vld", int'(vld_d), 1);
        chk("lat_c0_out", int'(out_d), 1);
        chk("lat_c0_out_z", int'(out_z), 0);

        // Challenge sweep 1,2,3.
        for (int c = 1; c < 4; c++) begin
            control_input = 2'(c);
            tick(1);
            chk("sweep_drop_vld", int'(vld_d), 0);
            tick(W + 1);
            chk("sweep_early_vld", int'(vld_d), 0);
            tick(1);
            chk("sweep_vld", int'(vld_d), 1);
            chk("sweep_out", int'(out_d), (c == 3) ? 1 : 0);
            chk("sweep_vld_z", int'(vld_z), 1);
            chk("sweep_out_z", int'(out_z), 0);
        end

        // Disable after a response of 1; remain idle for a long stretch.
        enable = 1'b0;
        tick(1);
        chk("dis_out", int'(out_d), 0);
        chk("dis_vld", int'(vld_d), 0);
        tick(10000);
        chk("dis_long_vld", int'(vld_d), 0);

        // Abort mid-window, then re-enable with challenge 3.
        control_input = 2'd2;
        enable = 1'b1;
        tick(1);
        tick(100);
        chk("abort_mid_vld", int'(vld_d), 0);
        enable = 1'b0;
        tick(1);
        chk("abort_vld", int'(vld_d), 0);
        control_input = 2'd3;
        enable = 1'b1;
        tick(1);
        tick(W + 1);
        chk("abort_early_vld", int'(vld_d), 0);
        chk("abort_early_out", int'(out_d), 0);
        tick(1);
        chk("abort_vld_re", int'(vld_d), 1);
        chk("abort_out_re", int'(out_d), 1);

        // Reach HOLD on challenge 0, then glitch 0->1->0.
        control_input = 2'd0;
        tick(W + 3);
        chk("glitch_pre_vld", int'(vld_d), 1);
        chk("glitch_pre_out", int'(out_d), 1);
        control_input = 2'd1;
        tick(1);
        chk("glitch1_vld", int'(vld_d), 0);
        chk("glitch1_out", int'(out_d), 1);
        control_input = 2'd0;
        tick(1);
        chk("glitch2_out", int'(out_d), 1);
        tick(W + 1);
        chk("glitch_early_vld", int'(vld_d), 0);
        chk("glitch_hold_out", int'(out_d), 1);
        tick(1);
        chk("glitch_vld", int'(vld_d), 1);
        chk("glitch_out", int'(out_d), 1);

        tick(4);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
